// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction-fetch stage that sits in front of the control unit. It owns the
// fetch PC and issues one word read at a time to instruction memory over a
// req/gnt/rvalid handshake. Returned words are queued in a small FIFO, and the
// head entry is presented with its decoded op/f3/f7 fields. A taken redirect
// (pcSrc on a pop) reloads the PC and flushes the FIFO. If a response is still
// in flight when the redirect happens, that response is dropped.
//
// Optional feature (compile-time macro FETCH_MISALIGN_TRAP_EN):
//   Adds the 'misaligned' output and a HALT state. A redirect to a target that
//   is not word-aligned sets a sticky flag and stops fetching until reset.
//   When the macro is undefined, the low target bits are masked off and fetch
//   continues.
//
// Parameters:
//   RESET_PC   PC loaded on reset (bits [1:0] must be zero)
//   BUF_DEPTH  instruction buffer entries, 2 or 4
//
// Ports:
//   clk, reset           clock (rising edge), synchronous active-high reset
//   imem_req/imem_addr   fetch request and word-aligned address
//   imem_gnt             request accepted this cycle
//   imem_rvalid/rdata    in-order read response
//   stall                downstream holds the current instruction
//   pcSrc/pcTarget       redirect request and target, sampled only on a pop
//   instr/instrValid     head instruction (NOP when empty) and non-empty flag
//   instrPC/pcPlus4      PC of the head instruction and that PC + 4
//   op/f3/f7             decoded fields of instr
//   misaligned           sticky misaligned-redirect flag (optional feature)
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        pcSrc,
    input  logic [31:0] pcTarget,
    output logic [31:0] instr,
    output logic        instrValid,
    output logic [31:0] instrPC,
    output logic [31:0] pcPlus4,
    output logic [6:0]  op,
    output logic [2:0]  f3,
    output logic [6:0]  f7
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic        misaligned
`endif
);

    localparam int unsigned    PtrW     = $clog2(BUF_DEPTH);
    localparam int unsigned    CntW     = PtrW + 1;
    localparam logic [CntW-1:0] DepthCnt = CntW'(BUF_DEPTH);
    localparam logic [31:0]    Nop      = 32'h0000_0013;

`ifdef FETCH_MISALIGN_TRAP_EN
    typedef enum logic [1:0] {StIdle, StWait, StDiscard, StHalt} state_e;
`else
    typedef enum logic [1:0] {StIdle, StWait, StDiscard} state_e;
`endif

    state_e          state_q, state_d;
    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic [31:0]     issued_pc_q, issued_pc_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0] count_q, count_d;

    logic [31:0]     buf_instr_q [BUF_DEPTH];
    logic [31:0]     buf_pc_q    [BUF_DEPTH];

    logic            pop;
    logic            push;
    logic            redirect;
    logic            buf_valid;
    logic [31:0]     target_aligned;

    assign buf_valid      = (count_q != '0);
    assign pop            = instrValid & ~stall;
    assign redirect       = pop & pcSrc;
    assign target_aligned = {pcTarget[31:2], 2'b00};

`ifdef FETCH_MISALIGN_TRAP_EN
    logic misaligned_q, misaligned_d;
    logic misalign_hit;

    assign misalign_hit = redirect & (pcTarget[1:0] != 2'b00);
    assign misaligned   = misaligned_q;
    // Halted: the buffer is flushed and never refilled, so the head is never shown.
    assign instrValid   = buf_valid & (state_q != StHalt);

    always_comb begin
        misaligned_d = misaligned_q;
        if (misalign_hit) begin
            misaligned_d = 1'b1;
        end
    end
`else
    logic unused_target_lsb;

    // The low target bits only matter when misalignment is trapped.
    assign unused_target_lsb = ^pcTarget[1:0];
    assign instrValid        = buf_valid;
`endif

    // -------------------------------------------------------------------------
    // Fetch FSM: at most one request outstanding
    // -------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        issued_pc_d = issued_pc_q;
        imem_req    = 1'b0;
        push        = 1'b0;

        case (state_q)
            StIdle: begin
                // One outstanding request at most, so a free slot is enough.
                imem_req = ~reset & (count_q < DepthCnt) & ~redirect;
                if (redirect) begin
                    if (imem_gnt) begin
                        state_d = StDiscard;
                    end
                end else if (imem_req && imem_gnt) begin
                    issued_pc_d = fetch_pc_q;
                    fetch_pc_d  = fetch_pc_q + 32'd4;
                    state_d     = StWait;
                end
            end
            StWait: begin
                if (imem_rvalid) begin
                    // A redirect in the same cycle makes the returning word stale.
                    push    = ~redirect;
                    state_d = StIdle;
                end else if (redirect) begin
                    state_d = StDiscard;
                end
            end
            StDiscard: begin
                if (imem_rvalid) begin
                    state_d = StIdle;
                end
            end
`ifdef FETCH_MISALIGN_TRAP_EN
            StHalt: begin
                state_d = StHalt;
            end
`endif
            default: begin
                state_d = StIdle;
            end
        endcase

        // A redirect takes priority over the sequential increment.
        if (redirect) begin
            fetch_pc_d = target_aligned;
        end
`ifdef FETCH_MISALIGN_TRAP_EN
        if (misalign_hit) begin
            state_d = StHalt;
        end
`endif
    end

    // -------------------------------------------------------------------------
    // Buffer pointers and occupancy
    // -------------------------------------------------------------------------
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;

        if (redirect) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            fetch_pc_q  <= RESET_PC;
            issued_pc_q <= RESET_PC;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            issued_pc_q <= issued_pc_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            misaligned_q <= 1'b0;
        end else begin
            misaligned_q <= misaligned_d;
        end
    end
`endif

    // Payload storage needs no reset; occupancy decides what is visible.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            buf_instr_q[wr_ptr_q] <= imem_rdata;
            buf_pc_q[wr_ptr_q]    <= issued_pc_q;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign imem_addr = fetch_pc_q;
    assign instr     = instrValid ? buf_instr_q[rd_ptr_q] : Nop;
    assign instrPC   = instrValid ? buf_pc_q[rd_ptr_q] : 32'h0000_0000;
    assign pcPlus4   = instrPC + 32'd4;
    assign op        = instr[6:0];
    assign f3        = instr[14:12];
    assign f7        = instr[31:25];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit with a one-outstanding memory model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        stall = 1'b0;
    logic        pcSrc = 1'b0;
    logic [31:0] pcTarget = 32'h0;
    logic [31:0] instr;
    logic        instrValid;
    logic [31:0] instrPC;
    logic [31:0] pcPlus4;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        misaligned;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Memory model: grants every request when enabled, answers one cycle later
    // unless the response is held back.
    logic        gnt_en   = 1'b1;
    logic        hold_rsp = 1'b0;
    logic        rsp_pend = 1'b0;
    logic [31:0] rsp_addr = 32'h0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h0001_0001) ^ 32'h8A5C_3033;
    endfunction

    assign imem_gnt    = imem_req & gnt_en;
    assign imem_rvalid = rsp_pend & ~hold_rsp;
    assign imem_rdata  = mem_word(rsp_addr);

    always @(posedge clk) begin
        if (imem_req && imem_gnt) begin
            rsp_pend <= 1'b1;
            rsp_addr <= imem_addr;
        end else if (imem_rvalid) begin
            rsp_pend <= 1'b0;
        end
    end

    always #5 clk = ~clk;

    fetch_unit #(
        .RESET_PC  (32'h0000_0000),
        .BUF_DEPTH (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .stall       (stall),
        .pcSrc       (pcSrc),
        .pcTarget    (pcTarget),
        .instr       (instr),
        .instrValid  (instrValid),
        .instrPC     (instrPC),
        .pcPlus4     (pcPlus4),
        .op          (op),
        .f3          (f3),
        .f7          (f7)
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        .misaligned  (misaligned)
`endif
    );

    // A push into a full two-entry buffer must never happen.
    always @(negedge clk) begin
        if (!reset && dut.push && dut.count_q == 2'd2) begin
            n_fail++;
            $display("FAIL push_full: got push with count %0d, expected no push", dut.count_q);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset    = 1'b1;
        stall    = 1'b0;
        pcSrc    = 1'b0;
        pcTarget = 32'h0;
        gnt_en   = 1'b1;
        hold_rsp = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        #1;
    endtask

    // Runs until the head shows the given PC; bounded.
    task automatic wait_head(input logic [31:0] pc, output bit found);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (instrValid && instrPC == pc) found = 1'b1;
            else tick();
        end
    endtask

    task automatic test_reset();
        logic [31:0]  ew;
        logic [112:0] exp_v;
        reset = 1'b1; stall = 1'b0; pcSrc = 1'b0; gnt_en = 1'b1; hold_rsp = 1'b0;
        tick();
        tick();
        n_checks++;
        if ({imem_req, instrValid, instr, instrPC, pcPlus4, imem_addr} !==
            {1'b0, 1'b0, 32'h13, 32'h0, 32'h4, 32'h0}) begin
            n_fail++;
            $display("FAIL reset_values: got %h, expected %h",
                {imem_req, instrValid, instr, instrPC, pcPlus4, imem_addr},
                {1'b0, 1'b0, 32'h13, 32'h0, 32'h4, 32'h0});
        end
        n_checks++;
        if ({op, f3, f7} !== {7'h13, 3'h0, 7'h00}) begin
            n_fail++;
            $display("FAIL reset_fields: got %h, expected %h", {op, f3, f7}, {7'h13, 3'h0, 7'h00});
        end
        reset = 1'b0;
        #1;
        n_checks++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin
            n_fail++;
            $display("FAIL first_req: got %h, expected %h", {imem_req, imem_addr}, {1'b1, 32'h0});
        end
        tick();
        n_checks++;
        if ({imem_req, instrValid} !== 2'b00) begin
            n_fail++;
            $display("FAIL wait_state: got %b, expected 00", {imem_req, instrValid});
        end
        tick();
        ew    = mem_word(32'h0);
        exp_v = {ew, 32'h0, 32'h4, ew[6:0], ew[14:12], ew[31:25]};
        n_checks++;
        if ({instr, instrPC, pcPlus4, op, f3, f7} !== exp_v || instrValid !== 1'b1) begin
            n_fail++;
            $display("FAIL first_instr: got %h valid %b, expected %h valid 1",
                {instr, instrPC, pcPlus4, op, f3, f7}, instrValid, exp_v);
        end
    endtask

    task automatic test_sequential();
        logic [31:0]  exp_addr = 32'h0;
        logic [31:0]  exp_pc = 32'h0;
        logic [31:0]  ew;
        logic [112:0] exp_v;
        int           n_req = 0;
        int           n_instr = 0;
        apply_reset();
        for (int k = 0; k < 24; k++) begin
            if (imem_req) begin
                n_checks++;
                if (imem_addr !== exp_addr) begin
                    n_fail++;
                    $display("FAIL seq_addr: got %h, expected %h", imem_addr, exp_addr);
                end
                exp_addr += 32'd4;
                n_req++;
            end
            if (instrValid) begin
                ew    = mem_word(exp_pc);
                exp_v = {ew, exp_pc, exp_pc + 32'd4, ew[6:0], ew[14:12], ew[31:25]};
                n_checks++;
                if ({instr, instrPC, pcPlus4, op, f3, f7} !== exp_v) begin
                    n_fail++;
                    $display("FAIL seq_instr: got %h, expected %h",
                        {instr, instrPC, pcPlus4, op, f3, f7}, exp_v);
                end
                exp_pc += 32'd4;
                n_instr++;
            end
            tick();
        end
        n_checks++;
        if (n_req != 12 || n_instr != 11) begin
            n_fail++;
            $display("FAIL seq_count: got %0d req %0d instr, expected 12 req 11 instr",
                n_req, n_instr);
        end
    endtask

    task automatic test_stall();
        logic [31:0] exp_pc = 32'h0;
        int          n_instr = 0;
        apply_reset();
        stall = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (k >= 4) begin
                n_checks++;
                if ({imem_req, instrValid, instrPC, instr} !== {1'b0, 1'b1, 32'h0, mem_word(32'h0)})
                begin
                    n_fail++;
                    $display("FAIL stall_hold: got %h, expected %h",
                        {imem_req, instrValid, instrPC, instr},
                        {1'b0, 1'b1, 32'h0, mem_word(32'h0)});
                end
            end
            tick();
        end
        stall = 1'b0;
        for (int j = 0; j < 12; j++) begin
            if (instrValid) begin
                n_checks++;
                if ({instrPC, instr} !== {exp_pc, mem_word(exp_pc)}) begin
                    n_fail++;
                    $display("FAIL stall_drain: got %h, expected %h",
                        {instrPC, instr}, {exp_pc, mem_word(exp_pc)});
                end
                exp_pc += 32'd4;
                n_instr++;
            end
            tick();
        end
        n_checks++;
        if (n_instr != 7) begin
            n_fail++;
            $display("FAIL stall_drain_count: got %0d, expected 7", n_instr);
        end
    endtask

    task automatic test_redirect_discard();
        bit found;
        apply_reset();
        wait_head(32'h10, found);
        n_checks++;
        if (!found || {imem_req, imem_addr} !== {1'b1, 32'h14}) begin
            n_fail++;
            $display("FAIL disc_setup: got found %b req/addr %h, expected found 1 %h",
                found, {imem_req, imem_addr}, {1'b1, 32'h14});
        end
        stall = 1'b1; hold_rsp = 1'b1;
        tick();
        stall = 1'b0; pcSrc = 1'b1; pcTarget = 32'h100;
        tick();
        pcSrc = 1'b0;
        n_checks++;
        if ({instrValid, imem_req} !== 2'b00) begin
            n_fail++;
            $display("FAIL disc_flush: got %b, expected 00", {instrValid, imem_req});
        end
        hold_rsp = 1'b0;
        tick();
        n_checks++;
        if ({instrValid, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h100}) begin
            n_fail++;
            $display("FAIL disc_drop: got %h, expected %h",
                {instrValid, imem_req, imem_addr}, {1'b0, 1'b1, 32'h100});
        end
        tick();
        tick();
        n_checks++;
        if ({instrValid, instrPC, pcPlus4, instr} !== {1'b1, 32'h100, 32'h104, mem_word(32'h100)})
        begin
            n_fail++;
            $display("FAIL disc_target: got %h, expected %h", {instrValid, instrPC, pcPlus4, instr},
                {1'b1, 32'h100, 32'h104, mem_word(32'h100)});
        end
    endtask

    task automatic test_redirect_rvalid();
        bit found;
        apply_reset();
        wait_head(32'h8, found);
        stall = 1'b1;
        tick();
        stall = 1'b0; pcSrc = 1'b1; pcTarget = 32'h200;
        tick();
        pcSrc = 1'b0;
        n_checks++;
        if (!found || {instrValid, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h200}) begin
            n_fail++;
            $display("FAIL rv_redirect: got found %b %h, expected found 1 %h",
                found, {instrValid, imem_req, imem_addr}, {1'b0, 1'b1, 32'h200});
        end
        tick();
        tick();
        n_checks++;
        if ({instrValid, instrPC, instr} !== {1'b1, 32'h200, mem_word(32'h200)}) begin
            n_fail++;
            $display("FAIL rv_target: got %h, expected %h", {instrValid, instrPC, instr},
                {1'b1, 32'h200, mem_word(32'h200)});
        end
    endtask

    task automatic test_misaligned();
        bit found;
        apply_reset();
        wait_head(32'h4, found);
        pcSrc = 1'b1; pcTarget = 32'h102;
        #1;
        n_checks++;
        if (!found || imem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL mis_req_suppress: got found %b req %b, expected found 1 req 0",
                found, imem_req);
        end
        tick();
        pcSrc = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if ({misaligned, imem_req, instrValid} !== 3'b100) begin
                n_fail++;
                $display("FAIL mis_halt: got %b, expected 100", {misaligned, imem_req, instrValid});
            end
            tick();
        end
`else
        n_checks++;
        if ({instrValid, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h100}) begin
            n_fail++;
            $display("FAIL mis_mask: got %h, expected %h",
                {instrValid, imem_req, imem_addr}, {1'b0, 1'b1, 32'h100});
        end
        tick();
        tick();
        n_checks++;
        if ({instrValid, instrPC, instr} !== {1'b1, 32'h100, mem_word(32'h100)}) begin
            n_fail++;
            $display("FAIL mis_target: got %h, expected %h", {instrValid, instrPC, instr},
                {1'b1, 32'h100, mem_word(32'h100)});
        end
`endif
    endtask

    task automatic test_wrap();
        bit found;
        apply_reset();
        wait_head(32'h0, found);
        pcSrc = 1'b1; pcTarget = 32'hFFFF_FFFC;
        tick();
        pcSrc = 1'b0;
        n_checks++;
        if (!found || {imem_req, imem_addr} !== {1'b1, 32'hFFFF_FFFC}) begin
            n_fail++;
            $display("FAIL wrap_req: got found %b %h, expected found 1 %h",
                found, {imem_req, imem_addr}, {1'b1, 32'hFFFF_FFFC});
        end
        tick();
        tick();
        n_checks++;
        if ({instrValid, instrPC, pcPlus4, instr, imem_req, imem_addr} !==
            {1'b1, 32'hFFFF_FFFC, 32'h0, mem_word(32'hFFFF_FFFC), 1'b1, 32'h0}) begin
            n_fail++;
            $display("FAIL wrap_head: got %h, expected %h",
                {instrValid, instrPC, pcPlus4, instr, imem_req, imem_addr},
                {1'b1, 32'hFFFF_FFFC, 32'h0, mem_word(32'hFFFF_FFFC), 1'b1, 32'h0});
        end
    endtask

    task automatic test_gnt_low_reset();
        apply_reset();
        gnt_en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            n_checks++;
            if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin
                n_fail++;
                $display("FAIL gnt_low_hold: got %h, expected %h", {imem_req, imem_addr},
                    {1'b1, 32'h0});
            end
            tick();
        end
        gnt_en = 1'b1; hold_rsp = 1'b1;
        tick();
        gnt_en = 1'b0; reset = 1'b1;
        tick();
        n_checks++;
        if ({imem_req, instrValid, imem_addr, instrPC, pcPlus4} !==
            {1'b0, 1'b0, 32'h0, 32'h0, 32'h4}) begin
            n_fail++;
            $display("FAIL mid_wait_reset: got %h, expected %h",
                {imem_req, instrValid, imem_addr, instrPC, pcPlus4},
                {1'b0, 1'b0, 32'h0, 32'h0, 32'h4});
        end
        reset = 1'b0; hold_rsp = 1'b0;
        tick();
        n_checks++;
        if ({instrValid, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h0}) begin
            n_fail++;
            $display("FAIL late_rvalid: got %h, expected %h", {instrValid, imem_req, imem_addr},
                {1'b0, 1'b1, 32'h0});
        end
        gnt_en = 1'b1;
        tick();
        tick();
        n_checks++;
        if ({instrValid, instrPC, instr} !== {1'b1, 32'h0, mem_word(32'h0)}) begin
            n_fail++;
            $display("FAIL after_reset_fetch: got %h, expected %h", {instrValid, instrPC, instr},
                {1'b1, 32'h0, mem_word(32'h0)});
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_discard();
        test_redirect_rvalid();
        test_misaligned();
        test_wrap();
        test_gnt_low_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no end of test, expected completion");
        $fatal(1, "timeout");
    end

endmodule
